// File: rtl/frame_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_pkg: state encoding and link constants shared by generator/receiver
// Rev 1.0
// ---------------------------------------------------------------------------
package frame_pkg;

  typedef enum logic [1:0] {
    HUNT_ZERO = 2'd0,
    HUNT_ONE  = 2'd1,
    CAPTURE   = 2'd2,
    PAYLOAD   = 2'd3
  } state_t;

  localparam int ZERO_LEN_TX = 32;
  localparam int ONES_LEN    = 8;
  localparam int SEQ_LEN     = 8;

endpackage
`default_nettype wire

// File: rtl/frame_sync_rx_run_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_counter: saturating run-length counter; clr+inc together loads 1
// Rev 1.0
// ---------------------------------------------------------------------------
module run_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
    end else if (inc && (count != '1)) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_sync_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_sync_rx: header hunter, first-sequence capture and payload forwarder
// Rev 1.0
// ---------------------------------------------------------------------------
module frame_sync_rx #(
  parameter int ZERO_MIN    = 16,
  parameter int ONES_LEN    = frame_pkg::ONES_LEN,
  parameter int SEQ_LEN     = frame_pkg::SEQ_LEN,
  parameter int PAYLOAD_LEN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_en,
  input  logic        data_in,
  input  logic        resync,
  output logic        locked,
  output logic        sync_found,
  output logic [7:0]  first_sequence,
  output logic        first_seq_valid,
  output logic        data_out,
  output logic        data_valid,
  output logic        frame_done,
  output logic [15:0] bit_count
);

  import frame_pkg::*;

  localparam logic [7:0]  ZERO_MIN_C = 8'(ZERO_MIN);
  localparam logic [7:0]  ONES_LAST  = 8'(ONES_LEN - 1);
  localparam logic [2:0]  SEQ_LAST   = 3'(SEQ_LEN - 1);
  localparam logic [15:0] PAY_LEN_C  = 16'(PAYLOAD_LEN);

  state_t      state, state_n;
  logic [7:0]  zero_cnt, ones_cnt;
  logic        zero_clr, zero_inc, ones_clr, ones_inc;
  logic [2:0]  cap_idx, cap_idx_n;
  logic [15:0] bit_count_n, bit_count_inc;
  logic [7:0]  first_seq_n;
  logic        fsv_n, data_out_n, data_valid_n, sync_n, frame_done_n;
  logic        header_done;

  run_counter #(.WIDTH(8)) u_zero_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (zero_clr),
    .inc   (zero_inc),
    .count (zero_cnt)
  );

  run_counter #(.WIDTH(8)) u_ones_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ones_clr),
    .inc   (ones_inc),
    .count (ones_cnt)
  );

  assign locked = (state == CAPTURE) || (state == PAYLOAD);

  always_comb begin
    state_n       = state;
    cap_idx_n     = cap_idx;
    bit_count_n   = bit_count;
    first_seq_n   = first_sequence;
    fsv_n         = first_seq_valid;
    data_out_n    = data_out;
    data_valid_n  = 1'b0;
    sync_n        = 1'b0;
    frame_done_n  = 1'b0;
    zero_clr      = 1'b0;
    zero_inc      = 1'b0;
    ones_clr      = 1'b0;
    ones_inc      = 1'b0;
    header_done   = 1'b0;
    bit_count_inc = (bit_count == 16'hFFFF) ? bit_count : bit_count + 16'd1;

    if (resync) begin
      state_n     = HUNT_ZERO;
      zero_clr    = 1'b1;
      ones_clr    = 1'b1;
      cap_idx_n   = 3'd0;
      bit_count_n = 16'd0;
      fsv_n       = 1'b0;
      first_seq_n = 8'h00;
    end else if (bit_en) begin
      case (state)
        HUNT_ZERO: begin
          if (!data_in) begin
            zero_inc = 1'b1;
          end else begin
            zero_clr = 1'b1;
            if (zero_cnt >= ZERO_MIN_C) begin
              ones_clr = 1'b1;
              ones_inc = 1'b1;
              if (ONES_LEN == 1) header_done = 1'b1;
              else               state_n     = HUNT_ONE;
            end
          end
        end
        HUNT_ONE: begin
          if (data_in) begin
            ones_inc = 1'b1;
            if (ones_cnt == ONES_LAST) header_done = 1'b1;
          end else begin
            // The violating zero starts the next zero run.
            state_n  = HUNT_ZERO;
            zero_clr = 1'b1;
            zero_inc = 1'b1;
          end
        end
        CAPTURE: begin
          data_out_n                 = data_in;
          data_valid_n               = 1'b1;
          bit_count_n                = bit_count_inc;
          first_seq_n[3'd7 - cap_idx] = data_in;
          cap_idx_n                  = cap_idx + 3'd1;
          if (cap_idx == SEQ_LAST) begin
            fsv_n = 1'b1;
            if (PAYLOAD_LEN == SEQ_LEN) begin
              frame_done_n = 1'b1;
              state_n      = HUNT_ZERO;
            end else begin
              state_n = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          data_out_n   = data_in;
          data_valid_n = 1'b1;
          bit_count_n  = bit_count_inc;
          if ((PAYLOAD_LEN != 0) && (bit_count_inc == PAY_LEN_C)) begin
            frame_done_n = 1'b1;
            state_n      = HUNT_ZERO;
          end
        end
        default: state_n = HUNT_ZERO;
      endcase

      if (header_done) begin
        state_n     = CAPTURE;
        sync_n      = 1'b1;
        first_seq_n = 8'h00;
        fsv_n       = 1'b0;
        bit_count_n = 16'd0;
        cap_idx_n   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HUNT_ZERO;
      cap_idx         <= 3'd0;
      bit_count       <= 16'd0;
      first_sequence  <= 8'h00;
      first_seq_valid <= 1'b0;
      data_out        <= 1'b0;
      data_valid      <= 1'b0;
      sync_found      <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state           <= state_n;
      cap_idx         <= cap_idx_n;
      bit_count       <= bit_count_n;
      first_sequence  <= first_seq_n;
      first_seq_valid <= fsv_n;
      data_out        <= data_out_n;
      data_valid      <= data_valid_n;
      sync_found      <= sync_n;
      frame_done      <= frame_done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_sync_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frame_sync_rx: directed bench for frame_sync_rx (unbounded + 20-bit frames)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_frame_sync_rx;

  logic clk = 1'b0, reset = 1'b1, bit_en = 1'b0, data_in = 1'b0, resync = 1'b0;

  logic        locked, sync_found, first_seq_valid, data_out, data_valid, frame_done;
  logic [7:0]  first_sequence;
  logic [15:0] bit_count;
  logic        locked_b, sync_found_b, first_seq_valid_b, data_out_b, data_valid_b, frame_done_b;
  logic [7:0]  first_sequence_b;
  logic [15:0] bit_count_b;

  int checks = 0, errors = 0;
  int sync_cnt = 0, dv_cnt = 0, fd_cnt = 0, lock_cyc = 0;
  int sync_cnt_b = 0, dv_cnt_b = 0, fd_cnt_b = 0, bc_at_fd_b = 0;
  int base_s, base_dv, base_lk, base_fd;
  logic [7:0] pat;

  always #5 clk = ~clk;

  frame_sync_rx #(.ZERO_MIN(16), .ONES_LEN(8), .SEQ_LEN(8), .PAYLOAD_LEN(0)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .data_in(data_in), .resync(resync),
    .locked(locked), .sync_found(sync_found), .first_sequence(first_sequence),
    .first_seq_valid(first_seq_valid), .data_out(data_out), .data_valid(data_valid),
    .frame_done(frame_done), .bit_count(bit_count)
  );

  frame_sync_rx #(.ZERO_MIN(16), .ONES_LEN(8), .SEQ_LEN(8), .PAYLOAD_LEN(20)) dut_b (
    .clk(clk), .reset(reset), .bit_en(bit_en), .data_in(data_in), .resync(resync),
    .locked(locked_b), .sync_found(sync_found_b), .first_sequence(first_sequence_b),
    .first_seq_valid(first_seq_valid_b), .data_out(data_out_b), .data_valid(data_valid_b),
    .frame_done(frame_done_b), .bit_count(bit_count_b)
  );

  // Pulse tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (sync_found)   sync_cnt   <= sync_cnt + 1;
    if (data_valid)   dv_cnt     <= dv_cnt + 1;
    if (frame_done)   fd_cnt     <= fd_cnt + 1;
    if (locked)       lock_cyc   <= lock_cyc + 1;
    if (sync_found_b) sync_cnt_b <= sync_cnt_b + 1;
    if (data_valid_b) dv_cnt_b   <= dv_cnt_b + 1;
    if (frame_done_b) begin
      fd_cnt_b   <= fd_cnt_b + 1;
      bc_at_fd_b <= int'(bit_count_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic b);
    data_in = b;
    bit_en  = 1'b1;
    @(posedge clk);
    #1;
    bit_en  = 1'b0;
  endtask

  task automatic drive_n(input logic b, input int n);
    repeat (n) drive(b);
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic header(input int zeros);
    drive_n(1'b0, zeros);
    drive_n(1'b1, 8);
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    @(posedge clk);
    #1;
    resync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_sync", 32'(sync_found), 0);
    check("rst_fseq", 32'(first_sequence), 0);
    check("rst_fsv", 32'(first_seq_valid), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_dvalid", 32'(data_valid), 0);
    check("rst_fdone", 32'(frame_done), 0);
    check("rst_bcount", 32'(bit_count), 0);
    reset = 1'b0;

    // Nominal header and 108-bit payload
    base_s = sync_cnt;
    drive_n(1'b0, 32);
    drive_n(1'b1, 7);
    check("nom_sync_early", 32'(sync_found), 0);
    check("nom_lock_early", 32'(locked), 0);
    drive(1'b1);
    check("nom_sync", 32'(sync_found), 1);
    check("nom_locked", 32'(locked), 1);
    base_dv = dv_cnt;
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      drive(pat[i]);
      if (i == 7) check("nom_sync_1cyc", 32'(sync_found), 0);
      if (i == 1) check("nom_fsv_early", 32'(first_seq_valid), 0);
    end
    check("nom_fseq", 32'(first_sequence), 32'hB2);
    check("nom_fsv", 32'(first_seq_valid), 1);
    check("nom_bcount8", 32'(bit_count), 8);
    check("nom_dout", 32'(data_out), 0);
    check("nom_dvalid", 32'(data_valid), 1);
    for (int i = 0; i < 100; i++) drive((i % 3) == 0);
    idle(1);
    check("nom_bcount108", 32'(bit_count), 108);
    check("nom_dv_total", 32'(dv_cnt - base_dv), 108);
    check("nom_sync_total", 32'(sync_cnt - base_s), 1);
    check("nom_dv_idle", 32'(data_valid), 0);

    // Short zero runs (10, then 15) must not lock; 16 does
    pulse_resync();
    base_s  = sync_cnt;
    base_lk = lock_cyc;
    drive_n(1'b0, 10);
    drive_n(1'b1, 8);
    for (int i = 0; i < 20; i++) drive((i % 2) == 1);
    drive_n(1'b0, 15);
    drive_n(1'b1, 8);
    idle(1);
    check("short_sync", 32'(sync_cnt - base_s), 0);
    check("short_lockcyc", 32'(lock_cyc - base_lk), 0);
    header(16);
    check("short_relock", 32'(locked), 1);
    check("short_resync_pulse", 32'(sync_found), 1);

    // Broken ones run
    pulse_resync();
    base_s = sync_cnt;
    drive_n(1'b0, 32);
    drive_n(1'b1, 5);
    drive(1'b0);
    drive_n(1'b1, 8);
    idle(1);
    check("broken_sync", 32'(sync_cnt - base_s), 0);
    check("broken_locked", 32'(locked), 0);
    header(16);
    check("broken_relock", 32'(sync_found), 1);

    // Two bounded 20-bit frames, bit_en every third clock
    pulse_resync();
    base_s  = sync_cnt_b;
    base_dv = dv_cnt_b;
    base_fd = fd_cnt_b;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 24; i++) begin
        drive(i >= 16);
        if (i == 23) check("bnd_sync", 32'(sync_found_b), 1);
        idle(2);
      end
      for (int i = 0; i < 20; i++) begin
        drive((i % 2) == 1);
        if (i == 18) check("bnd_fdone_early", 32'(frame_done_b), 0);
        if (i == 19) begin
          check("bnd_fdone", 32'(frame_done_b), 1);
          check("bnd_dv_last", 32'(data_valid_b), 1);
          check("bnd_bcount", 32'(bit_count_b), 20);
          check("bnd_unlocked", 32'(locked_b), 0);
        end
        idle(2);
      end
      check("bnd_fdone_1cyc", 32'(frame_done_b), 0);
      check("bnd_bcount_hold", 32'(bit_count_b), 20);
    end
    check("bnd_sync_total", 32'(sync_cnt_b - base_s), 2);
    check("bnd_dv_total", 32'(dv_cnt_b - base_dv), 40);
    check("bnd_fd_total", 32'(fd_cnt_b - base_fd), 2);
    check("bnd_bc_at_fd", 32'(bc_at_fd_b), 20);

    // resync mid-payload together with bit_en
    pulse_resync();
    header(16);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) drive(pat[i]);
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    check("rs_fseq_pre", 32'(first_sequence), 32'hA5);
    check("rs_bcount_pre", 32'(bit_count), 11);
    resync  = 1'b1;
    bit_en  = 1'b1;
    data_in = 1'b1;
    @(posedge clk);
    #1;
    resync = 1'b0;
    bit_en = 1'b0;
    check("rs_locked", 32'(locked), 0);
    check("rs_fseq", 32'(first_sequence), 0);
    check("rs_fsv", 32'(first_seq_valid), 0);
    check("rs_bcount", 32'(bit_count), 0);
    check("rs_dvalid", 32'(data_valid), 0);
    header(16);
    check("rs_relock", 32'(sync_found), 1);

    // Reset in CAPTURE after four captured bits
    pulse_resync();
    header(16);
    drive(1'b1);
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    check("mr_fseq_pre", 32'(first_sequence), 32'hD0);
    check("mr_bcount_pre", 32'(bit_count), 4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mr_locked", 32'(locked), 0);
    check("mr_sync", 32'(sync_found), 0);
    check("mr_fseq", 32'(first_sequence), 0);
    check("mr_fsv", 32'(first_seq_valid), 0);
    check("mr_dout", 32'(data_out), 0);
    check("mr_dvalid", 32'(data_valid), 0);
    check("mr_fdone", 32'(frame_done), 0);
    check("mr_bcount", 32'(bit_count), 0);
    check("mr_locked_b", 32'(locked_b), 0);
    reset = 1'b0;
    header(16);
    check("mr_relock", 32'(sync_found), 1);
    check("mr_relocked", 32'(locked), 1);

    idle(1);
    check("unbounded_no_fdone", 32'(fd_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
